// File: rtl/div_unit.sv
// 32-bit iterative restoring divider (DIV/DIVU): 32 cycles per result, {HI=rem, LO=quot}.
// Optional `define DIV_ZERO_EN adds a short DZERO path for zero divisors and drives div_zero_o.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        div_zero_o
);

`ifdef DIV_ZERO_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, END = 2'd2, DZERO = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, END = 2'd2} state_t;
`endif

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [32:0] rem_q;
  logic [31:0] quo_q;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [31:0] dvs_q;
  logic        qneg_q;
  logic        rneg_q;
  logic [63:0] result_q;
  logic        ready_q;
`ifdef DIV_ZERO_EN
  logic        dz_q;
`endif

  logic [31:0] op1_abs, op2_abs;
  logic [32:0] rem_sh, diff, rem_d;
  logic [31:0] quo_d, q_fix, r_fix;
  logic        ge;

  assign op1_abs = (signed_div_i & opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign op2_abs = (signed_div_i & opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // A set top bit means the shifted remainder already exceeds any 32-bit divisor.
  assign rem_sh = {rem_q[31:0], quo_q[31]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign ge     = rem_q[32] | ~diff[32];
  assign rem_d  = ge ? diff : rem_sh;
  assign quo_d  = {quo_q[30:0], ge};

  assign q_fix = qneg_q ? (~quo_d + 32'd1) : quo_d;
  assign r_fix = rneg_q ? (~rem_d[31:0] + 32'd1) : rem_d[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      rem_q    <= 33'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
`ifdef DIV_ZERO_EN
      dz_q     <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef DIV_ZERO_EN
      dz_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start_i && !annul_i) begin
`ifdef DIV_ZERO_EN
            state_q <= (opdata2_i == 32'd0) ? DZERO : ON;
`else
            state_q <= ON;
`endif
            quo_q  <= op1_abs;
            dvs_q  <= op2_abs;
            rem_q  <= 33'd0;
            cnt_q  <= 6'd0;
            qneg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            rneg_q <= signed_div_i & opdata1_i[31];
          end
        end
        ON: begin
          if (annul_i) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q == 6'd31) begin
              state_q  <= END;
              result_q <= {r_fix, q_fix};
              ready_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        END: state_q <= IDLE;
`ifdef DIV_ZERO_EN
        DZERO: begin
          if (annul_i) begin
            state_q <= IDLE;
          end else begin
            state_q  <= END;
            result_q <= 64'd0;
            ready_q  <= 1'b1;
            dz_q     <= 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q == ON) | ((state_q == IDLE) & start_i & ~annul_i);
`ifdef DIV_ZERO_EN
  assign div_zero_o = dz_q;
`else
  assign div_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, busy profile, sign fix-up, annul, async reset.
`timescale 1ns/100ps
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic        div_zero_o;

  int n_chk = 0;
  int n_err = 0;

  div_unit dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o), .div_zero_o(div_zero_o)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts an op in the current cycle (cycle 0) and observes ncyc further cycles.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int ann_cyc, input int ncyc, input bit chk_busy,
                        output int rdy_cyc, output int npulse, output int busy_err,
                        output logic dz_at_rdy);
    logic exp_busy;
    rdy_cyc = -1; npulse = 0; busy_err = 0; dz_at_rdy = 1'b0;
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    #1;
    if (chk_busy && busy_o !== 1'b1) busy_err++;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      annul_i = (c == ann_cyc);
      #1;
      exp_busy = (c <= 32) && !(ann_cyc > 0 && c > ann_cyc);
      if (chk_busy && busy_o !== exp_busy) busy_err++;
      if (ready_o === 1'b1) begin
        npulse++;
        if (rdy_cyc < 0) begin rdy_cyc = c; dz_at_rdy = div_zero_o; end
      end else if (div_zero_o !== 1'b0) begin
        busy_err++;
      end
    end
    annul_i = 1'b0;
  endtask

  task automatic div_case(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res);
    int rc, np, be;
    logic dz;
    run_op(sgn, a, b, 0, 34, 1'b1, rc, np, be, dz);
    chk({tag, "_rdy_cyc"}, 64'(rc), 64'd33);
    chk({tag, "_pulses"}, 64'(np), 64'd1);
    chk({tag, "_busy"}, 64'(be), 64'd0);
    chk({tag, "_dz"}, {63'd0, dz}, 64'd0);
    chk({tag, "_result"}, result_o, exp_res);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, np, be;
    logic dz;
    logic [63:0] last;

    rst = 1'b1;
    #3;
    chk("rst_result", result_o, 64'd0);
    chk("rst_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_dz", {63'd0, div_zero_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    div_case("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    div_case("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
    div_case("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    div_case("divu_max_16", 1'b0, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF);
    div_case("div_7_m2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);

`ifdef DIV_ZERO_EN
    run_op(1'b0, 32'd5, 32'd0, 0, 4, 1'b0, rc, np, be, dz);
    chk("divu_5_0_rdy_cyc", 64'(rc), 64'd2);
    chk("divu_5_0_dz", {63'd0, dz}, 64'd1);
    chk("divu_5_0_result", result_o, 64'd0);
`else
    div_case("divu_5_0", 1'b0, 32'd5, 32'd0, 64'h00000005_FFFFFFFF);
    div_case("div_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_00000001);
`endif

    // annul in END must not suppress the pulse already scheduled
    run_op(1'b0, 32'd100, 32'd7, 33, 34, 1'b0, rc, np, be, dz);
    chk("annul_end_rdy_cyc", 64'(rc), 64'd33);
    chk("annul_end_result", result_o, 64'h00000002_0000000E);

    // annul mid-run, then restart at cycle 12
    last = result_o;
    run_op(1'b0, 32'd1000, 32'd3, 10, 11, 1'b1, rc, np, be, dz);
    chk("annul_on_pulses", 64'(np), 64'd0);
    chk("annul_on_busy", 64'(be), 64'd0);
    chk("annul_on_result_kept", result_o, last);
    @(negedge clk);
    #1;
    chk("annul_idle_ready", {63'd0, ready_o}, 64'd0);
    div_case("restart_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    // async reset in cycle 15 of a run
    run_op(1'b0, 32'd50, 32'd5, 0, 15, 1'b1, rc, np, be, dz);
    #1 rst = 1'b1;
    #1;
    chk("arst_result", result_o, 64'd0);
    chk("arst_ready", {63'd0, ready_o}, 64'd0);
    chk("arst_busy", {63'd0, busy_o}, 64'd0);
    chk("arst_dz", {63'd0, div_zero_o}, 64'd0);
    #1 rst = 1'b0;
    div_case("post_rst_50_5", 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
